duty_scan_ctrl: RTL and testbench
=================================

Name: duty_scan_ctrl

Overview:
- Round-robin scheduler that shares one duty-measurement unit between NUM_CH PWM inputs.
- Muxes the selected PWM onto pwm_sel, which feeds the shared unit.
- Discards the partial first period after each channel switch, captures the unit's duty result after one clean period, then advances to the next channel.
- Flags channels whose PWM never toggles (stuck high or stuck low).

Parameters:
NUM_CH, 4, number of PWM channels scanned (2..16)
CNT_W, 10, width of duty result from the measurement unit
TIMEOUT, 4096, max cycles to wait for a rising edge in SYNC or MEAS
SETTLE, 2, cycles held after a channel switch before edges are honoured

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
en  in  1  scan enable
pwm  in  NUM_CH  raw PWM inputs
pwm_sel  out  1  PWM of current channel, to measurement unit
meas_duty  in  CNT_W  duty result from measurement unit
ch  out  CH_W  current channel index; CH_W = max(1, clog2(NUM_CH))
duty_wr  out  1  one-cycle strobe: duty_out valid for ch
duty_out  out  CNT_W  measured duty for ch
stuck  out  NUM_CH  per-channel stuck flag
scan_done  out  1  one-cycle strobe, coincident with duty_wr of channel NUM_CH-1

Behaviour:
- Reset (asynchronous, any state): state=IDLE; ch=0; duty_wr=0; duty_out=0; stuck=0; scan_done=0; timeout counter=0; edge-detect flop=0.
- pwm_sel = pwm[ch], combinational from registered ch.
- Internal edge detect: rise = pwm_sel & ~pwm_sel_d. pwm_sel_d is updated every cycle.
- States: IDLE, SETTLE, SYNC, MEAS, CAPTURE, NEXT.
- IDLE: when en=1, go to SETTLE with ch unchanged.
- SETTLE: count SETTLE cycles, ignoring rise, then go to SYNC and clear the timeout counter.
- SYNC: on rise, go to MEAS and clear the timeout counter. This edge is discarded because the shared unit holds stale data.
- MEAS: on rise at cycle t, go to CAPTURE. The unit updates its duty output at the end of cycle t.
- CAPTURE (cycle t+1): register meas_duty into duty_out and clear stuck[ch]; duty_wr=1 in cycle t+2. Then go to NEXT.
- Timeout: in SYNC or MEAS, if the counter reaches TIMEOUT-1 with no rise:
  - duty_out = pwm_sel ? all-ones : 0
  - stuck[ch]=1
  - duty_wr pulse, timed as for CAPTURE
  - go to NEXT
- NEXT (1 cycle): ch = (ch==NUM_CH-1) ? 0 : ch+1, wrapping; go to SETTLE. scan_done=1 in the same cycle as duty_wr when the written ch was NUM_CH-1.
- duty_wr and scan_done are registered, high for exactly 1 cycle. ch is stable while duty_wr=1.
- en=0 in any non-IDLE state: abort next cycle to IDLE, no duty_wr, ch=0, stuck retained. A duty_wr already in flight still completes.
- rise exactly when the timeout count expires: rise wins.
- duty_out holds its last value between strobes.
- Timeout counter width: clog2(TIMEOUT)+1, no wrap.

Optional Feature:
- Macro: DUTY_SCAN_SYNC_EN.
- Defined: each pwm bit passes a 2-flop synchronizer (reset to 0) before the mux. pwm_sel lags raw pwm by 2 cycles; all timing is relative to pwm_sel.
- Undefined: pwm is assumed synchronous to clk and muxed directly.

Test Plan:
- NUM_CH=4, ch0 period 100, high 30, en=1 -> first duty_wr has ch=0, duty_out=30; scan then moves to ch=1.
- ch1 held 0, others toggling -> after SETTLE+TIMEOUT cycles in SYNC: duty_wr with ch=1, duty_out=0, stuck[1]=1.
- ch2 held 1 -> duty_wr with duty_out=0x3FF and stuck[2]=1; ch2 later toggling period 50, high 20 -> next pass duty_out=20, stuck[2]=0.
- All 4 channels toggling -> duty_wr sequence ch 0,1,2,3,0; scan_done=1 only with the ch=3 strobe.
- en dropped mid-MEAS on ch1 -> no duty_wr for ch1, state IDLE, ch=0; en re-raised -> scan restarts at ch0.
- rst pulsed during MEAS -> all outputs 0 immediately (asynchronous), ch=0; release with en=1 -> normal scan from ch0.

Source files
------------

// File: rtl/duty_scan_ctrl.sv
// duty_scan_ctrl: round-robin scheduler sharing one duty-measurement unit across NUM_CH PWM inputs.
// Latency: duty_wr_o two cycles after the closing rising edge (or timeout expiry) on pwm_sel_o.
// Backpressure: none; en_i low aborts the scan to IDLE/ch 0, a result already being written completes.
//
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous reset, active-high
//   en_i         scan enable
//   pwm_i        raw PWM inputs, one bit per channel
//   pwm_sel_o    PWM of the current channel, drives the shared measurement unit
//   meas_duty_i  duty result from the measurement unit
//   ch_o         current channel index
//   duty_wr_o    one-cycle strobe: duty_out_o is valid for ch_o
//   duty_out_o   measured duty (all-ones / zero for a channel stuck high / low)
//   stuck_o      per-channel flag, set when the channel showed no rising edge
//   scan_done_o  one-cycle strobe coincident with the duty_wr_o of channel NUM_CH-1
//
// Build option: define DUTY_SCAN_SYNC_EN to pass every pwm_i bit through a 2-flop
// synchronizer before the channel mux (pwm_sel_o then lags pwm_i by 2 cycles).

module duty_scan_ctrl #(
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 10,
   parameter int TIMEOUT = 4096,
   parameter int SETTLE  = 2,
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic [NUM_CH-1:0] pwm_i,
   output logic              pwm_sel_o,
   input  logic [CNT_W-1:0]  meas_duty_i,
   output logic [CH_W-1:0]   ch_o,
   output logic              duty_wr_o,
   output logic [CNT_W-1:0]  duty_out_o,
   output logic [NUM_CH-1:0] stuck_o,
   output logic              scan_done_o
);

   localparam int CW = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0]   TO_LAST  = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0]   SET_LAST = CW'((SETTLE > 0) ? SETTLE - 1 : 0);
   localparam logic [CH_W-1:0] CH_LAST  = CH_W'(NUM_CH - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SETTLE = 3'd1;
   localparam logic [2:0] S_SYNC   = 3'd2;
   localparam logic [2:0] S_MEAS   = 3'd3;
   localparam logic [2:0] S_CAPT   = 3'd4;
   localparam logic [2:0] S_NEXT   = 3'd5;

   logic [NUM_CH-1:0] pwm_s;

`ifdef DUTY_SCAN_SYNC_EN
   logic [NUM_CH-1:0] sync1_q, sync2_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= pwm_i;
         sync2_q <= sync1_q;
      end
   end

   assign pwm_s = sync2_q;
`else
   assign pwm_s = pwm_i;
`endif

   logic [2:0]        state_q, state_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              to_q, to_d;     // result comes from a timeout, not a measurement
   logic              lvl_q, lvl_d;   // pwm_sel level at timeout expiry
   logic [CNT_W-1:0]  duty_q, duty_d;
   logic [NUM_CH-1:0] stuck_q, stuck_d;
   logic              wr_q, wr_d;
   logic              sd_q, sd_d;
   logic              sel_d_q;
   logic              pwm_sel;
   logic              rise;

   assign pwm_sel = pwm_s[ch_q];
   assign rise    = pwm_sel & ~sel_d_q;

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      cnt_d   = cnt_q;
      to_d    = to_q;
      lvl_d   = lvl_q;
      duty_d  = duty_q;
      stuck_d = stuck_q;
      wr_d    = 1'b0;
      sd_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (en_i) state_d = S_SETTLE;
         end
         // Edges right after a mux switch are artefacts of the switch itself.
         S_SETTLE: begin
            if (cnt_q >= SET_LAST) begin
               state_d = S_SYNC;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         // SYNC discards the first edge: the shared unit still holds data from the
         // previous channel. The edge closing the next full period is the one kept.
         // A rise coinciding with expiry is honoured.
         S_SYNC, S_MEAS: begin
            if (rise) begin
               cnt_d   = '0;
               to_d    = 1'b0;
               state_d = (state_q == S_SYNC) ? S_MEAS : S_CAPT;
            end else if (cnt_q == TO_LAST) begin
               to_d    = 1'b1;
               lvl_d   = pwm_sel;
               state_d = S_CAPT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_CAPT: begin
            duty_d        = to_q ? {CNT_W{lvl_q}} : meas_duty_i;
            stuck_d[ch_q] = to_q;
            wr_d          = 1'b1;
            sd_d          = (ch_q == CH_LAST);
            state_d       = S_NEXT;
         end
         // ch advances at the end of this cycle, so it is stable during duty_wr.
         S_NEXT: begin
            ch_d    = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
            cnt_d   = '0;
            state_d = S_SETTLE;
         end
         default: state_d = S_IDLE;
      endcase

      // CAPTURE is allowed to finish so a captured result is always written out;
      // the abort then takes effect from NEXT.
      if (!en_i && state_q != S_IDLE && state_q != S_CAPT) begin
         state_d = S_IDLE;
         ch_d    = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         ch_q    <= '0;
         cnt_q   <= '0;
         to_q    <= 1'b0;
         lvl_q   <= 1'b0;
         duty_q  <= '0;
         stuck_q <= '0;
         wr_q    <= 1'b0;
         sd_q    <= 1'b0;
         sel_d_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         cnt_q   <= cnt_d;
         to_q    <= to_d;
         lvl_q   <= lvl_d;
         duty_q  <= duty_d;
         stuck_q <= stuck_d;
         wr_q    <= wr_d;
         sd_q    <= sd_d;
         sel_d_q <= pwm_sel;
      end
   end

   assign pwm_sel_o   = pwm_sel;
   assign ch_o        = ch_q;
   assign duty_wr_o   = wr_q;
   assign duty_out_o  = duty_q;
   assign stuck_o     = stuck_q;
   assign scan_done_o = sd_q;

endmodule

// File: tb/tb_duty_scan_ctrl.sv
// tb_duty_scan_ctrl: directed bench for duty_scan_ctrl with a behavioural measurement unit.
// Latency: expected results are queued when stimulus is set and compared on each duty_wr_o.
// Backpressure: not applicable; en_i toggled to exercise abort/restart.

module tb_duty_scan_ctrl;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 10;
   localparam int CH_W   = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              en  = 1'b0;
   logic [NUM_CH-1:0] pwm = '0;
   logic              pwm_sel;
   logic [CNT_W-1:0]  meas_duty = '0;
   logic [CH_W-1:0]   ch;
   logic              duty_wr;
   logic [CNT_W-1:0]  duty_out;
   logic [NUM_CH-1:0] stuck;
   logic              scan_done;

   duty_scan_ctrl #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .TIMEOUT(4096), .SETTLE(2)
   ) dut (
      .clk_i(clk), .rst_i(rst), .en_i(en), .pwm_i(pwm), .pwm_sel_o(pwm_sel),
      .meas_duty_i(meas_duty), .ch_o(ch), .duty_wr_o(duty_wr), .duty_out_o(duty_out),
      .stuck_o(stuck), .scan_done_o(scan_done)
   );

   always #5 clk = ~clk;

   // PWM sources: per-channel period/high, updated just after each rising edge.
   int per [NUM_CH];
   int hi  [NUM_CH];
   int ph  [NUM_CH];

   always @(posedge clk) begin
      #1;
      for (int i = 0; i < NUM_CH; i++) begin
         ph[i]  = (ph[i] + 1 >= per[i]) ? 0 : ph[i] + 1;
         pwm[i] = (ph[i] < hi[i]);
      end
   end

   // Shared measurement unit: on each rise of pwm_sel publishes the high-time of the
   // period that just closed.
   logic [CNT_W-1:0] hcnt = '0;
   logic             mprev = 1'b0;
   always @(posedge clk) begin
      if (pwm_sel && !mprev) begin
         meas_duty <= hcnt;
         hcnt      <= 1;
      end else if (pwm_sel) begin
         hcnt <= hcnt + 1'b1;
      end
      mprev <= pwm_sel;
   end

   int wr_total = 0;
   always @(negedge clk) if (duty_wr === 1'b1) wr_total++;

   typedef struct {
      logic [CH_W-1:0]   ch;
      logic [CNT_W-1:0]  duty;
      logic [NUM_CH-1:0] stuck;
      logic              sd;
   } exp_t;

   exp_t sb[$];
   int   n_push = 0;
   int   n_eval = 0;
   int   n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_eval++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_ch(input int i, input int p, input int h);
      per[i] = p;
      hi[i]  = h;
      ph[i]  = 0;
   endtask

   task automatic push(input int c, input int d, input int s, input int sd);
      exp_t e;
      e.ch    = CH_W'(c);
      e.duty  = CNT_W'(d);
      e.stuck = NUM_CH'(s);
      e.sd    = sd[0];
      sb.push_back(e);
      n_push++;
   endtask

   task automatic expect_wr(input string tag);
      exp_t e;
      bit   seen;
      logic [CNT_W-1:0] held;
      seen = 1'b0;
      e = sb.pop_front();
      for (int n = 0; n < 6000 && !seen; n++) begin
         @(negedge clk);
         if (duty_wr === 1'b1) seen = 1'b1;
      end
      chk({tag, " strobe"}, 32'(seen), 32'd1);
      if (seen) begin
         chk({tag, " ch"}, 32'(ch), 32'(e.ch));
         chk({tag, " duty"}, 32'(duty_out), 32'(e.duty));
         chk({tag, " stuck"}, 32'(stuck), 32'(e.stuck));
         chk({tag, " scan_done"}, 32'(scan_done), 32'(e.sd));
         held = duty_out;
         @(negedge clk);
         chk({tag, " wr width"}, 32'(duty_wr), 32'd0);
         chk({tag, " duty hold"}, 32'(duty_out), 32'(held));
      end
   endtask

   // Settle runs out, then waits for the SYNC edge; returns on the negedge of that rise.
   task automatic wait_sync_rise(input string tag);
      bit   got;
      logic prev;
      got = 1'b0;
      @(negedge clk);
      prev = pwm_sel;
      for (int n = 0; n < 300 && !got; n++) begin
         @(negedge clk);
         if (pwm_sel && !prev) got = 1'b1;
         prev = pwm_sel;
      end
      chk({tag, " sync rise"}, 32'(got), 32'd1);
   endtask

   initial begin
      int wr_snap;
      set_ch(0, 100, 30);
      set_ch(1, 50, 0);
      set_ch(2, 50, 50);
      set_ch(3, 60, 45);

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst ch", 32'(ch), 32'd0);
      chk("rst duty_wr", 32'(duty_wr), 32'd0);
      chk("rst duty_out", 32'(duty_out), 32'd0);
      chk("rst stuck", 32'(stuck), 32'd0);
      chk("rst scan_done", 32'(scan_done), 32'd0);
      chk("rst pwm_sel", 32'(pwm_sel), 32'(pwm[0]));
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("idle ch", 32'(ch), 32'd0);
      chk("idle no wr", 32'(wr_total), 32'd0);

      // Pass 1: ch0 30/100, ch1 stuck low, ch2 stuck high, ch3 45/60
      en = 1'b1;
      push(0, 30, 4'b0000, 0);
      push(1, 0, 4'b0010, 0);
      push(2, 10'h3FF, 4'b0110, 0);
      push(3, 45, 4'b0110, 1);
      expect_wr("p1 ch0");
      chk("p1 advance ch", 32'(ch), 32'd1);
      expect_wr("p1 ch1");
      expect_wr("p1 ch2");
      set_ch(2, 50, 20);
      expect_wr("p1 ch3");

      // Pass 2: ch2 recovers
      push(0, 30, 4'b0110, 0);
      push(1, 0, 4'b0110, 0);
      push(2, 20, 4'b0010, 0);
      push(3, 45, 4'b0010, 1);
      expect_wr("p2 ch0");
      expect_wr("p2 ch1");
      set_ch(1, 40, 10);
      expect_wr("p2 ch2");
      expect_wr("p2 ch3");

      // Pass 3: abort in MEAS on ch1
      push(0, 30, 4'b0010, 0);
      expect_wr("p3 ch0");
      chk("p3 ch1 selected", 32'(ch), 32'd1);
      wait_sync_rise("abort");
      wr_snap = wr_total;
      repeat (10) @(negedge clk);
      en = 1'b0;
      repeat (2) @(negedge clk);
      chk("abort ch", 32'(ch), 32'd0);
      repeat (100) @(negedge clk);
      chk("abort no wr", 32'(wr_total), 32'(wr_snap));
      chk("abort ch idle", 32'(ch), 32'd0);
      chk("abort stuck kept", 32'(stuck), 32'b0010);

      // Restart from ch0
      en = 1'b1;
      push(0, 30, 4'b0010, 0);
      push(1, 10, 4'b0000, 0);
      expect_wr("re ch0");
      expect_wr("re ch1");

      // Asynchronous reset during MEAS on ch2
      chk("rst2 ch2 selected", 32'(ch), 32'd2);
      wait_sync_rise("rst2");
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst ch", 32'(ch), 32'd0);
      chk("arst duty_out", 32'(duty_out), 32'd0);
      chk("arst stuck", 32'(stuck), 32'd0);
      chk("arst duty_wr", 32'(duty_wr), 32'd0);
      chk("arst scan_done", 32'(scan_done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      push(0, 30, 4'b0000, 0);
      push(1, 10, 4'b0000, 0);
      push(2, 20, 4'b0000, 0);
      push(3, 45, 4'b0000, 1);
      expect_wr("post ch0");
      expect_wr("post ch1");
      expect_wr("post ch2");
      expect_wr("post ch3");
      repeat (5) @(negedge clk);
      chk("total strobes", 32'(wr_total), 32'(n_push));

      $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
      $finish;
   end

endmodule
